// File: rtl/td_launch_capture_if.sv
// Bundle of handshake, launch and capture signals for td_launch_capture.
// slave is the stage side; master is the producer/cone side.
interface td_launch_capture_if #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned ERR_W = 8
);
   logic                     in_valid;
   logic [5:0]               in_data;
   logic                     in_ready;
   logic                     launch_en;
   logic [5:0]               a_out;
   logic                     y1_in;
   logic                     y2_in;
   logic                     res_valid;
   logic [1:0]               res_data;
   logic                     busy;
   logic [$clog2(DEPTH):0]   level;
   logic                     chk_err;
   logic [ERR_W-1:0]         err_count;

   modport master (
      output in_valid, in_data, launch_en, y1_in, y2_in,
      input  in_ready, a_out, res_valid, res_data, busy, level, chk_err, err_count
   );

   modport slave (
      input  in_valid, in_data, launch_en, y1_in, y2_in,
      output in_ready, a_out, res_valid, res_data, busy, level, chk_err, err_count
   );
endinterface

// File: rtl/td_launch_capture.sv
// Registered launch/capture stage around the td1 cone: FIFO-buffered vectors launch from a register
// and cone outputs are captured CAP_DELAY edges later. Golden checker enabled by TD_LAUNCH_CHECK_EN.
module td_launch_capture #(
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned CAP_DELAY = 1,
   parameter int unsigned ERR_W     = 8
) (
   input logic               clk,
   input logic               rst,
   td_launch_capture_if.slave bus_io
);
   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned LvlW = PtrW + 1;

   typedef enum logic {StIdle, StSettle} state_e;

   logic [5:0]      mem_q [DEPTH];
   logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
   logic [LvlW-1:0] level_q;
   state_e          state_q;
   logic [3:0]      cnt_q;
   logic [5:0]      a_q;
   logic [1:0]      res_q;
   logic            res_valid_q;
   logic            push, pop, capture;

   assign bus_io.in_ready = (level_q < LvlW'(DEPTH));
   assign push    = bus_io.in_valid && bus_io.in_ready;
   assign pop     = (state_q == StIdle) && bus_io.launch_en && (level_q != '0);
   assign capture = (state_q == StSettle) && (cnt_q == '0);

   // Storage needs no reset; only pointers and level define occupancy.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= bus_io.in_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
         if (push && !pop)      level_q <= level_q + LvlW'(1);
         else if (pop && !push) level_q <= level_q - LvlW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         a_q         <= '0;
         res_q       <= '0;
         res_valid_q <= 1'b0;
      end else begin
         res_valid_q <= 1'b0;
         case (state_q)
            StIdle: begin
               if (pop) begin
                  a_q     <= mem_q[rd_ptr_q];
                  cnt_q   <= 4'(CAP_DELAY - 1);
                  state_q <= StSettle;
               end
            end
            StSettle: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - 4'd1;
               end else begin
                  res_q       <= {bus_io.y2_in, bus_io.y1_in};
                  res_valid_q <= 1'b1;
                  state_q     <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus_io.a_out     = a_q;
   assign bus_io.res_data  = res_q;
   assign bus_io.res_valid = res_valid_q;
   assign bus_io.busy      = (state_q != StIdle);
   assign bus_io.level     = level_q;

`ifdef TD_LAUNCH_CHECK_EN
   logic             y1_exp, y2_exp, mismatch;
   logic             chk_err_q;
   logic [ERR_W-1:0] err_count_q;

   assign y1_exp   = ~(a_q[0] & a_q[1]) & a_q[2];
   assign y2_exp   = (&a_q[5:3]) & y1_exp;
   assign mismatch = capture && ({bus_io.y2_in, bus_io.y1_in} != {y2_exp, y1_exp});

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         chk_err_q   <= 1'b0;
         err_count_q <= '0;
      end else if (mismatch) begin
         chk_err_q <= 1'b1;
         if (err_count_q != '1) err_count_q <= err_count_q + ERR_W'(1);
      end
   end

   assign bus_io.chk_err   = chk_err_q;
   assign bus_io.err_count = err_count_q;
`else
   assign bus_io.chk_err   = 1'b0;
   assign bus_io.err_count = ERR_W'(0);
`endif
endmodule

// File: tb/tb_td_launch_capture.sv
// Directed bench for td_launch_capture: two instances (CAP_DELAY=1 and 3) with a modelled td1 cone
// and per-instance result scoreboards.
module tb_td_launch_capture;
   localparam int unsigned Depth = 4;
   localparam int unsigned ErrW  = 8;

   logic       clk;
   logic       rst;
   logic       bad;
   int         n_tests = 0;
   int         n_fail  = 0;
   int         res_cnt1 = 0;
   int         res_cnt3 = 0;
   int         snap;
   bit         armed  = 0;
   bit         seen15 = 0;
   logic [1:0] q1[$];
   logic [1:0] q3[$];
   logic [7:0] exp_err_cnt;
   logic       exp_err;

   td_launch_capture_if #(.DEPTH(Depth), .ERR_W(ErrW)) bus1 ();
   td_launch_capture_if #(.DEPTH(Depth), .ERR_W(ErrW)) bus3 ();

   td_launch_capture #(.DEPTH(Depth), .CAP_DELAY(1), .ERR_W(ErrW)) u_dut1 (
      .clk    (clk),
      .rst    (rst),
      .bus_io (bus1)
   );

   td_launch_capture #(.DEPTH(Depth), .CAP_DELAY(3), .ERR_W(ErrW)) u_dut3 (
      .clk    (clk),
      .rst    (rst),
      .bus_io (bus3)
   );

   function automatic logic [1:0] cone(input logic [5:0] a);
      logic y1;
      y1 = ~(a[0] & a[1]) & a[2];
      return {(&a[5:3]) & y1, y1};
   endfunction

   // Cone models; bad corrupts y2 on the CAP_DELAY=3 instance only.
   assign bus1.y1_in = cone(bus1.a_out)[0];
   assign bus1.y2_in = cone(bus1.a_out)[1];
   assign bus3.y1_in = cone(bus3.a_out)[0];
   assign bus3.y2_in = cone(bus3.a_out)[1] & ~bad;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout required finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input bit sel3, input logic [5:0] d);
      if (sel3) begin bus3.in_valid = 1'b1; bus3.in_data = d; end
      else      begin bus1.in_valid = 1'b1; bus1.in_data = d; end
      tick();
      bus1.in_valid = 1'b0;
      bus3.in_valid = 1'b0;
   endtask

   // Scoreboards: expectation queued when a push is seen, checked when res_valid appears.
   always @(negedge clk) begin
      if (rst) begin
         q1.delete();
      end else if (armed) begin
         if (bus1.a_out == 6'h15) seen15 = 1'b1;
         if (bus1.res_valid) begin
            res_cnt1++;
            check("dut1 pending", 32'(q1.size() != 0), 32'd1);
            if (q1.size() != 0) check("dut1 res_data", 32'(bus1.res_data), 32'(q1.pop_front()));
         end
         if (bus1.in_valid && bus1.in_ready) q1.push_back(cone(bus1.in_data));
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         q3.delete();
      end else if (armed) begin
         if (bus3.res_valid) begin
            res_cnt3++;
            check("dut3 pending", 32'(q3.size() != 0), 32'd1);
            if (q3.size() != 0) check("dut3 res_data", 32'(bus3.res_data), 32'(q3.pop_front()));
         end
         if (bus3.in_valid && bus3.in_ready) q3.push_back(cone(bus3.in_data) & {~bad, 1'b1});
      end
   end

   initial begin
      rst = 1'b0;
      bad = 1'b0;
      bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.launch_en = 1'b0;
      bus3.in_valid = 1'b0; bus3.in_data = '0; bus3.launch_en = 1'b0;

      // Reset asserted mid-cycle, no clock edge in between.
      tick();
      tick();
      #2 rst = 1'b1;
      #1;
      check("rst a_out", 32'(bus1.a_out), 32'h0);
      check("rst res_valid", 32'(bus1.res_valid), 32'h0);
      check("rst level", 32'(bus1.level), 32'h0);
      check("rst in_ready", 32'(bus1.in_ready), 32'h1);
      check("rst busy", 32'(bus1.busy), 32'h0);
      check("rst level3", 32'(bus3.level), 32'h0);
      tick();
      tick();
      rst = 1'b0;
      armed = 1'b1;

      // Fill with launch_en low, then offer a fifth vector while full.
      push(1'b0, 6'h3F);
      push(1'b0, 6'h01);
      push(1'b0, 6'h3C);
      push(1'b0, 6'h2A);
      check("fill level", 32'(bus1.level), 32'd4);
      check("fill in_ready", 32'(bus1.in_ready), 32'd0);
      push(1'b0, 6'h15);
      check("full level", 32'(bus1.level), 32'd4);
      bus1.launch_en = 1'b1;
      repeat (20) tick();
      bus1.launch_en = 1'b0;
      check("drain count", 32'(res_cnt1), 32'd4);
      check("drain level", 32'(bus1.level), 32'd0);
      check("dropped 15", 32'(seen15), 32'd0);

      // Single launch with CAP_DELAY=1.
      push(1'b0, 6'h3C);
      bus1.launch_en = 1'b1;
      tick();
      bus1.launch_en = 1'b0;
      check("single a_out", 32'(bus1.a_out), 32'h3C);
      check("single busy", 32'(bus1.busy), 32'd1);
      check("single early valid", 32'(bus1.res_valid), 32'd0);
      tick();
      check("single valid", 32'(bus1.res_valid), 32'd1);
      check("single res_data", 32'(bus1.res_data), 32'd3);
      check("single busy done", 32'(bus1.busy), 32'd0);
      tick();
      check("single pulse", 32'(bus1.res_valid), 32'd0);
      check("single hold", 32'(bus1.res_data), 32'd3);
      check("single a_out hold", 32'(bus1.a_out), 32'h3C);

      // Back-to-back with CAP_DELAY=3: one result every 4 cycles.
      push(1'b1, 6'h3C);
      push(1'b1, 6'h3F);
      push(1'b1, 6'h00);
      check("b2b level", 32'(bus3.level), 32'd3);
      bus3.launch_en = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick();
         check("b2b res_valid", 32'(bus3.res_valid), 32'((i % 4) == 3));
         if ((i % 4) == 0) check("b2b level", 32'(bus3.level), 32'(2 - i / 4));
      end
      bus3.launch_en = 1'b0;
      tick();
      check("b2b count", 32'(res_cnt3), 32'd3);

      // Reset while a capture is in flight.
      push(1'b1, 6'h3C);
      bus3.launch_en = 1'b1;
      tick();
      bus3.launch_en = 1'b0;
      check("inflight busy", 32'(bus3.busy), 32'd1);
      tick();
      snap = res_cnt3;
      #2 rst = 1'b1;
      #1;
      check("inflight level", 32'(bus3.level), 32'd0);
      check("inflight a_out", 32'(bus3.a_out), 32'h0);
      check("inflight busy rst", 32'(bus3.busy), 32'd0);
      check("inflight valid", 32'(bus3.res_valid), 32'd0);
      tick();
      tick();
      rst = 1'b0;
      repeat (5) tick();
      check("inflight no result", 32'(res_cnt3), 32'(snap));
      check("inflight in_ready", 32'(bus3.in_ready), 32'd1);

      // Wrong y2 response, then a correct one.
`ifdef TD_LAUNCH_CHECK_EN
      exp_err     = 1'b1;
      exp_err_cnt = 8'd1;
`else
      exp_err     = 1'b0;
      exp_err_cnt = 8'd0;
`endif
      bad = 1'b1;
      push(1'b1, 6'h3C);
      bus3.launch_en = 1'b1;
      tick();
      bus3.launch_en = 1'b0;
      repeat (5) tick();
      bad = 1'b0;
      check("chk_err bad", 32'(bus3.chk_err), 32'(exp_err));
      check("err_count bad", 32'(bus3.err_count), 32'(exp_err_cnt));
      push(1'b1, 6'h00);
      bus3.launch_en = 1'b1;
      tick();
      bus3.launch_en = 1'b0;
      repeat (5) tick();
      check("chk_err sticky", 32'(bus3.chk_err), 32'(exp_err));
      check("err_count hold", 32'(bus3.err_count), 32'(exp_err_cnt));
      check("dut1 chk_err", 32'(bus1.chk_err), 32'd0);

      check("q1 empty", 32'(q1.size()), 32'd0);
      check("q3 empty", 32'(q3.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/td_launch_capture.md
Name: td_launch_capture

Overview:
- Registered launch/capture stage wrapped around the combinational `td1` cone: feeds `a1..a6` and consumes `y1/y2`.
- Buffers operand vectors in a small FIFO and launches one vector onto the cone's inputs from a register.
- Waits a programmable settle time, then samples the cone outputs into a result register with a valid pulse.
- Gives the cone a clean reg-to-reg timing path for resizer/pin-swap timing and equivalence runs.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, minimum 2.
- CAP_DELAY, 1, clock edges from the launch edge to the capture edge; legal range 1..15.
- ERR_W, 8, width of the error counter (optional feature).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand vector offered.
- in_data  input  6  operand vector; bit0=a1, bit1=a2, bit2=a3, bit3=a4, bit4=a5, bit5=a6.
- in_ready  output  1  FIFO can accept a vector.
- launch_en  input  1  permits popping the FIFO and launching.
- a_out  output  6  registered launch vector to the cone; same bit order as in_data.
- y1_in  input  1  cone output y1.
- y2_in  input  1  cone output y2.
- res_valid  output  1  one-cycle pulse: res_data is new.
- res_data  output  2  captured {y2,y1}.
- busy  output  1  FSM is not in IDLE.
- level  output  $clog2(DEPTH)+1  FIFO occupancy.
- chk_err  output  1  sticky mismatch flag (optional feature).
- err_count  output  ERR_W  mismatch count (optional feature).

Behaviour:
- Reset values (asynchronous): a_out=0, res_data=0, res_valid=0, busy=0, level=0, in_ready=1, chk_err=0, err_count=0, FSM=IDLE, FIFO pointers=0.
- in_ready = (level < DEPTH).
- Push occurs when in_valid && in_ready.
- Full FIFO: no push and no bypass; in_data is ignored and in_valid is not an error.
- Pop is allowed only in IDLE, when launch_en=1 and level>0.
- Push and pop in the same cycle: level is unchanged, both pointers advance and wrap modulo DEPTH.
- Pop on an empty FIFO never happens.
- FSM state IDLE:
  - On a pop edge (T0): a_out <= FIFO head, delay counter <= CAP_DELAY-1, go to SETTLE.
  - Otherwise hold.
- FSM state SETTLE:
  - If counter != 0: decrement.
  - If counter == 0 (this is edge T0+CAP_DELAY): res_data <= {y2_in,y1_in}, res_valid <= 1, go to IDLE.
- res_valid is high for exactly one cycle. A new launch may occur on the edge that clears res_valid.
- Throughput: one vector per CAP_DELAY+1 cycles while launch_en=1 and the FIFO is non-empty.
- Vectors launch in FIFO order. Results appear in the same order.
- a_out holds the last launched vector between launches. res_data holds its value until the next capture.
- launch_en dropping during SETTLE has no effect; the in-flight capture completes.
- Reset asserted mid-operation: everything returns to reset values immediately. The in-flight result is discarded (no res_valid) and the FIFO is flushed.
- level updates on the same edge as the push or pop and is visible the next cycle.

Optional Feature:
- Macro TD_LAUNCH_CHECK_EN.
- Defined:
  - On each capture edge, compare {y2_in,y1_in} against a golden model computed from the launched a_out:
    - y1_exp = ~(a1&a2) & a3
    - y2_exp = a4&a5&a6&y1_exp
  - On a mismatch: chk_err <= 1 (sticky until rst), and err_count increments, saturating at 2^ERR_W-1.
- Not defined: chk_err and err_count are tied to 0 and no comparator logic is built. All other behaviour is identical.

Test Plan:
- Reset: assert rst mid-cycle, no clock edge needed -> a_out=0, res_valid=0, level=0, in_ready=1, busy=0.
- Fill: launch_en=0, push 4 vectors 6'h3F, 6'h01, 6'h3C, 6'h2A -> level=4, in_ready=0. A 5th push of 6'h15 is dropped. After draining, 6'h15 never appears on a_out.
- Single launch, CAP_DELAY=1: push 6'h3C, pulse launch_en; bench models the cone (y1=1, y2=1) -> a_out=6'h3C one edge after the pop, res_valid pulses on the next edge with res_data=2'b11, busy high for 1 cycle.
- Back-to-back, CAP_DELAY=3: push 6'h3C, 6'h3F, 6'h00; hold launch_en=1 -> res_valid every 4 cycles with res_data 2'b11, 2'b00, 2'b00 in order. level decrements 3->0.
- Reset in flight, CAP_DELAY=3: push 6'h3C, launch, assert rst while busy=1 -> no res_valid, level=0, a_out=0. After rst is released, in_ready=1.
- Checker (TD_LAUNCH_CHECK_EN): launch 6'h3C, bench forces y2_in=0 -> chk_err=1, err_count=1. Then launch 6'h00 with a correct response -> chk_err stays 1, err_count stays 1.
